// File: rtl/akuma_pkg.sv
// Shared types, screen constants and small helpers for the Akuma controller.
package akuma_pkg;

    localparam logic [9:0] X_MIN     = 10'd0;
    localparam logic [9:0] X_MAX     = 10'd560;
    localparam logic [9:0] X_INIT    = 10'd400;
    localparam logic [9:0] Y_GROUND  = 10'd300;
    localparam logic [9:0] WALK_STEP = 10'd2;

    localparam logic signed [6:0] JUMP_V0 = 7'sd12;
    localparam logic signed [6:0] GRAVITY = 7'sd1;

    localparam int PUNCH_FRAMES = 12;
    localparam int PULSE_FRAMES = 30;
    localparam int TIMER_W      = 5;

    localparam logic [TIMER_W-1:0] PUNCH_LOAD = TIMER_W'(PUNCH_FRAMES - 1);
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_FRAMES - 1);

    typedef enum logic [3:0] {
        SPR_STAND    = 4'd0,
        SPR_PULSE    = 4'd1,
        SPR_PUNCH    = 4'd2,
        SPR_JUMP     = 4'd3,
        SPR_CROUCH   = 4'd4,
        SPR_LEFT     = 4'd5,
        SPR_RIGHT    = 4'd6,
        SPR_DEATH    = 4'd7,
        SPR_JUMP_ATK = 4'd8
    } sprite_code_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WALK_L,
        ST_WALK_R,
        ST_CROUCH,
        ST_PUNCH,
        ST_PULSE,
        ST_JUMP,
        ST_JUMP_ATK,
        ST_DEAD
    } motion_state_t;

    typedef enum logic [1:0] {
        DRIFT_NONE,
        DRIFT_L,
        DRIFT_R
    } drift_t;

    function automatic sprite_code_t state_sprite(input motion_state_t s);
        case (s)
            ST_IDLE:     return SPR_STAND;
            ST_WALK_L:   return SPR_LEFT;
            ST_WALK_R:   return SPR_RIGHT;
            ST_CROUCH:   return SPR_CROUCH;
            ST_PUNCH:    return SPR_PUNCH;
            ST_PULSE:    return SPR_PULSE;
            ST_JUMP:     return SPR_JUMP;
            ST_JUMP_ATK: return SPR_JUMP_ATK;
            ST_DEAD:     return SPR_DEATH;
            default:     return SPR_STAND;
        endcase
    endfunction

    // Saturating horizontal steps; X never wraps past the screen edges.
    function automatic logic [9:0] x_left(input logic [9:0] x);
        return (x < X_MIN + WALK_STEP) ? X_MIN : x - WALK_STEP;
    endfunction

    function automatic logic [9:0] x_right(input logic [9:0] x);
        return (x > X_MAX - WALK_STEP) ? X_MAX : x + WALK_STEP;
    endfunction

endpackage

// File: rtl/akuma_jump_physics.sv
// Vertical jump physics: holds AkumaY and the signed vertical velocity.
// Landing is flagged combinationally so the FSM can leave the air on the
// same tick the ground is reached.
module akuma_jump_physics
    import akuma_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_step,
    input  logic       i_snap,
    output logic [9:0] o_y,
    output logic       o_landed
);

    logic [9:0]         r_y;
    logic signed [6:0]  r_vy;
    logic signed [10:0] w_y_sum;
    logic [9:0]         w_y_clamped;

    // Screen Y grows downward, so rising means subtracting a positive vy.
    assign w_y_sum     = $signed({1'b0, r_y}) - $signed({{4{r_vy[6]}}, r_vy});
    assign w_y_clamped = w_y_sum[10] ? 10'd0 : w_y_sum[9:0];
    assign o_landed    = r_vy[6] && (w_y_sum >= $signed({1'b0, Y_GROUND}));
    assign o_y         = r_y;

    // Position/velocity update; snap (death) beats start beats step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y  <= Y_GROUND;
            r_vy <= '0;
        end else if (i_snap) begin
            r_y  <= Y_GROUND;
            r_vy <= '0;
        end else if (i_start) begin
            r_vy <= JUMP_V0;
        end else if (i_step) begin
            if (o_landed) begin
                r_y  <= Y_GROUND;
                r_vy <= '0;
            end else begin
                r_y  <= w_y_clamped;
                r_vy <= r_vy - GRAVITY;
            end
        end
    end

endmodule

// File: rtl/akuma_motion_fsm.sv
// Akuma character controller: turns button levels into a pose code and a
// sprite anchor, advancing only on frame_tick.
//
//   state       | meaning
//   ------------+------------------------------------------------
//   ST_IDLE     | standing on the ground, no input
//   ST_WALK_L   | walking left, X moves every tick
//   ST_WALK_R   | walking right, X moves every tick
//   ST_CROUCH   | down held
//   ST_PUNCH    | ground punch, timed, hitbox on
//   ST_PULSE    | special move, timed
//   ST_JUMP     | airborne, ballistic
//   ST_JUMP_ATK | airborne attack, hitbox on until landing
//   ST_DEAD     | absorbing until reset
module akuma_motion_fsm
    import akuma_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_punch,
    input  logic       btn_special,
    input  logic       dead,
    output logic [3:0] sprite,
    output logic [9:0] AkumaX,
    output logic [9:0] AkumaY,
    output logic       attack_active,
    output logic       busy
);

    motion_state_t      r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [9:0]         r_x;
    drift_t             r_drift;
    logic               r_punch_q;
    logic               r_special_q;
    sprite_code_t       r_sprite;
    logic               r_attack;
    logic               r_busy;

    motion_state_t      w_next_state;
    logic [TIMER_W-1:0] w_next_timer;
    logic [9:0]         w_next_x;
    drift_t             w_next_drift;
    logic               w_jump_start;
    logic               w_jump_step;
    logic               w_snap;
    logic               w_landed;
    logic               w_punch_edge;
    logic               w_special_edge;
    logic               w_left_only;
    logic               w_right_only;

    assign w_punch_edge   = btn_punch & ~r_punch_q;
    assign w_special_edge = btn_special & ~r_special_q;
    assign w_left_only    = btn_left & ~btn_right;
    assign w_right_only   = btn_right & ~btn_left;

    akuma_jump_physics u_phys (
        .i_clk    (vga_clk),
        .i_rst_n  (reset_n),
        .i_start  (w_jump_start),
        .i_step   (w_jump_step),
        .i_snap   (w_snap),
        .o_y      (AkumaY),
        .o_landed (w_landed)
    );

    // Next-state, timer, X and physics enables; nothing moves without a tick.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_x     = r_x;
        w_next_drift = r_drift;
        w_jump_start = 1'b0;
        w_jump_step  = 1'b0;
        w_snap       = 1'b0;
        if (frame_tick) begin
            if (dead) begin
                w_next_state = ST_DEAD;
                w_snap       = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE, ST_WALK_L, ST_WALK_R, ST_CROUCH: begin
                        if (w_punch_edge) begin
                            w_next_state = ST_PUNCH;
                            w_next_timer = PUNCH_LOAD;
                        end else if (w_special_edge) begin
                            w_next_state = ST_PULSE;
                            w_next_timer = PULSE_LOAD;
                        end else if (btn_up) begin
                            w_next_state = ST_JUMP;
                            w_jump_start = 1'b1;
                            if (w_left_only)       w_next_drift = DRIFT_L;
                            else if (w_right_only) w_next_drift = DRIFT_R;
                            else                   w_next_drift = DRIFT_NONE;
                        end else if (btn_down) begin
                            w_next_state = ST_CROUCH;
                        end else if (w_left_only) begin
                            w_next_state = ST_WALK_L;
                            w_next_x     = x_left(r_x);
                        end else if (w_right_only) begin
                            w_next_state = ST_WALK_R;
                            w_next_x     = x_right(r_x);
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end
                    ST_PUNCH, ST_PULSE: begin
                        if (r_timer == '0) w_next_state = ST_IDLE;
                        else               w_next_timer = r_timer - TIMER_W'(1);
                    end
                    ST_JUMP, ST_JUMP_ATK: begin
                        w_jump_step = 1'b1;
                        if (r_drift == DRIFT_L)      w_next_x = x_left(r_x);
                        else if (r_drift == DRIFT_R) w_next_x = x_right(r_x);
                        if (w_landed)
                            w_next_state = ST_IDLE;
                        else if (r_state == ST_JUMP && w_punch_edge)
                            w_next_state = ST_JUMP_ATK;
                    end
                    ST_DEAD: begin
                        w_next_state = ST_DEAD;
                    end
                    default: begin
                        w_next_state = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State register, button history and registered pose outputs.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_x         <= X_INIT;
            r_drift     <= DRIFT_NONE;
            r_punch_q   <= 1'b0;
            r_special_q <= 1'b0;
            r_sprite    <= SPR_STAND;
            r_attack    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_timer  <= w_next_timer;
            r_x      <= w_next_x;
            r_drift  <= w_next_drift;
            r_sprite <= state_sprite(w_next_state);
            r_attack <= (w_next_state == ST_PUNCH) || (w_next_state == ST_JUMP_ATK);
            r_busy   <= (w_next_state == ST_PUNCH) || (w_next_state == ST_PULSE) ||
                        (w_next_state == ST_JUMP)  || (w_next_state == ST_JUMP_ATK) ||
                        (w_next_state == ST_DEAD);
            if (frame_tick) begin
                r_punch_q   <= btn_punch;
                r_special_q <= btn_special;
            end
        end
    end

    assign sprite        = r_sprite;
    assign AkumaX        = r_x;
    assign attack_active = r_attack;
    assign busy          = r_busy;

endmodule

// File: tb/tb_akuma_motion_fsm.sv
// Bench for akuma_motion_fsm: vector table plus hand-written jump/punch/death
// sequences, with expectations queued and retired after each frame tick.
module tb_akuma_motion_fsm;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       btn_punch = 1'b0, btn_special = 1'b0, dead = 1'b0;
    logic [3:0] sprite;
    logic [9:0] AkumaX, AkumaY;
    logic       attack_active, busy;

    always #5 vga_clk = ~vga_clk;

    akuma_motion_fsm dut (
        .vga_clk       (vga_clk),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_punch     (btn_punch),
        .btn_special   (btn_special),
        .dead          (dead),
        .sprite        (sprite),
        .AkumaX        (AkumaX),
        .AkumaY        (AkumaY),
        .attack_active (attack_active),
        .busy          (busy)
    );

    typedef struct packed {
        logic l, r, u, d, p, s, k;
    } in_t;

    localparam in_t NONE = 7'b0000000;
    localparam in_t IN_L = 7'b1000000;
    localparam in_t IN_R = 7'b0100000;
    localparam in_t IN_U = 7'b0010000;
    localparam in_t IN_D = 7'b0001000;
    localparam in_t IN_P = 7'b0000100;
    localparam in_t IN_S = 7'b0000010;
    localparam in_t IN_K = 7'b0000001;

    typedef struct {
        string      name;
        logic [3:0] spr;
        logic [9:0] x;
        logic [9:0] y;
        logic       atk;
        logic       bsy;
    } exp_t;

    typedef struct {
        string      name;
        in_t        in;
        int         n;
        logic [3:0] spr;
        logic [9:0] x;
        logic       atk;
        logic       bsy;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string nm, input in_t in, input int n, input int spr,
                                input int x, input bit atk, input bit bsy);
        vec_t v;
        v.name = nm; v.in = in; v.n = n; v.spr = 4'(spr); v.x = 10'(x);
        v.atk = atk; v.bsy = bsy;
        return v;
    endfunction

    // Height after t physics ticks of a default jump (closed form).
    function automatic int jump_y(input int t);
        return 300 - (13 * t - (t * (t + 1)) / 2);
    endfunction

    task automatic push_exp(input string nm, input int spr, input int x, input int y,
                            input bit atk, input bit bsy);
        exp_t e;
        e.name = nm; e.spr = 4'(spr); e.x = 10'(x); e.y = 10'(y); e.atk = atk; e.bsy = bsy;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expectation queued");
        end else begin
            e = sb.pop_front();
            if (sprite !== e.spr || AkumaX !== e.x || AkumaY !== e.y ||
                attack_active !== e.atk || busy !== e.bsy) begin
                n_fail++;
                $display("FAIL %s: got spr=%0d x=%0d y=%0d atk=%0b busy=%0b, want spr=%0d x=%0d y=%0d atk=%0b busy=%0b",
                         e.name, sprite, AkumaX, AkumaY, attack_active, busy,
                         e.spr, e.x, e.y, e.atk, e.bsy);
            end
        end
    endtask

    task automatic drive(input in_t in);
        btn_left    = in.l;
        btn_right   = in.r;
        btn_up      = in.u;
        btn_down    = in.d;
        btn_punch   = in.p;
        btn_special = in.s;
        dead        = in.k;
    endtask

    // One frame: inputs and strobe set at a falling edge, outputs sampled at the next.
    task automatic tick(input in_t in);
        @(negedge vga_clk);
        drive(in);
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_check(input in_t in, input string nm, input int spr, input int x,
                              input int y, input bit atk, input bit bsy);
        push_exp(nm, spr, x, y, atk, bsy);
        tick(in);
        check_front();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sx;
        in_t in;

        tbl.push_back(mk("idle_3",        NONE,      3,  0, 400, 0, 0));
        tbl.push_back(mk("walk_l_5",      IN_L,      5,  5, 390, 0, 0));
        tbl.push_back(mk("release",       NONE,      1,  0, 390, 0, 0));
        tbl.push_back(mk("walk_r_3",      IN_R,      3,  6, 396, 0, 0));
        tbl.push_back(mk("left_right",    IN_L|IN_R, 1,  0, 396, 0, 0));
        tbl.push_back(mk("crouch",        IN_D,      2,  4, 396, 0, 0));
        tbl.push_back(mk("down_over_l",   IN_D|IN_L, 1,  4, 396, 0, 0));
        tbl.push_back(mk("stand",         NONE,      1,  0, 396, 0, 0));
        tbl.push_back(mk("pulse_enter",   IN_S,      1,  1, 396, 0, 1));
        tbl.push_back(mk("pulse_last",    NONE,      29, 1, 396, 0, 1));
        tbl.push_back(mk("pulse_exit",    NONE,      1,  0, 396, 0, 0));
        tbl.push_back(mk("punch_over_s",  IN_S|IN_P, 1,  2, 396, 1, 1));
        tbl.push_back(mk("punch_last",    NONE,      11, 2, 396, 1, 1));
        tbl.push_back(mk("punch_exit",    NONE,      1,  0, 396, 0, 0));
        tbl.push_back(mk("walk_to_xmin",  IN_L,      198, 5, 0, 0, 0));
        tbl.push_back(mk("sat_xmin",      IN_L,      3,  5, 0, 0, 0));
        tbl.push_back(mk("walk_to_558",   IN_R,      279, 6, 558, 0, 0));
        tbl.push_back(mk("reach_xmax",    IN_R,      1,  6, 560, 0, 0));
        tbl.push_back(mk("sat_xmax",      IN_R,      2,  6, 560, 0, 0));
        tbl.push_back(mk("back_to_400",   IN_L,      80, 5, 400, 0, 0));
        tbl.push_back(mk("stand_400",     NONE,      1,  0, 400, 0, 0));

        drive(NONE);
        repeat (3) @(negedge vga_clk);
        push_exp("reset_values", 0, 400, 300, 0, 0);
        check_front();
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n - 1; k++) tick(tbl[i].in);
            tick_check(tbl[i].in, tbl[i].name, tbl[i].spr, tbl[i].x, 300, tbl[i].atk, tbl[i].bsy);
        end

        // Held punch: exactly 12 ticks of pose, no retrigger while held.
        for (int t = 1; t <= 20; t++)
            tick_check(IN_P, "punch_held", (t <= 12) ? 2 : 0, 400, 300, t <= 12, t <= 12);
        tick_check(NONE, "punch_release", 0, 400, 300, 0, 0);

        // Straight jump.
        tick_check(IN_U, "jump_enter", 3, 400, 300, 0, 1);
        for (int t = 1; t <= 25; t++) begin
            tick_check(NONE, "jump_air", (t < 25) ? 3 : 0, 400, jump_y(t), 0, t < 25);
            if (t == 3) begin
                repeat (3) @(negedge vga_clk);
                push_exp("hold_no_tick", 3, 400, jump_y(3), 0, 1);
                check_front();
            end
        end

        // Jump attack with a second, ignored punch edge.
        tick_check(IN_U, "jatk_enter", 3, 400, 300, 0, 1);
        for (int t = 1; t <= 25; t++) begin
            in = ((t >= 5 && t <= 10) || (t >= 15 && t <= 19)) ? IN_P : NONE;
            tick_check(in, "jump_attack", (t < 5) ? 3 : (t < 25) ? 8 : 0, 400, jump_y(t),
                       (t >= 5 && t < 25), t < 25);
        end

        // Leftward drift latched at takeoff.
        tick_check(IN_U|IN_L, "drift_enter", 3, 400, 300, 0, 1);
        for (int t = 1; t <= 25; t++)
            tick_check(NONE, "drift_air", (t < 25) ? 3 : 0, 400 - 2 * t, jump_y(t), 0, t < 25);

        // Death at the apex, then everything ignored.
        sx = 350;
        tick_check(IN_U, "dead_jump", 3, sx, 300, 0, 1);
        for (int t = 1; t <= 12; t++)
            tick_check(NONE, "dead_rise", 3, sx, jump_y(t), 0, 1);
        tick_check(IN_K, "dead_enter", 7, sx, 300, 0, 1);
        tick_check(IN_L|IN_P, "dead_hold", 7, sx, 300, 0, 1);
        tick_check(IN_U,      "dead_hold", 7, sx, 300, 0, 1);
        tick_check(IN_S,      "dead_hold", 7, sx, 300, 0, 1);
        tick_check(IN_R|IN_D, "dead_hold", 7, sx, 300, 0, 1);
        tick_check(NONE,      "dead_hold", 7, sx, 300, 0, 1);
        @(negedge vga_clk);
        reset_n = 1'b0;
        #2;
        push_exp("reset_from_dead", 0, 400, 300, 0, 0);
        check_front();
        @(negedge vga_clk);
        reset_n = 1'b1;
        tick_check(NONE, "after_reset", 0, 400, 300, 0, 0);

        // Reset asserted mid-jump clears immediately.
        tick_check(IN_U, "mid_jump_enter", 3, 400, 300, 0, 1);
        for (int t = 1; t <= 5; t++)
            tick_check(NONE, "mid_jump_air", 3, 400, jump_y(t), 0, 1);
        @(negedge vga_clk);
        #3;
        reset_n = 1'b0;
        #1;
        push_exp("reset_mid_jump", 0, 400, 300, 0, 0);
        check_front();
        @(negedge vga_clk);
        reset_n = 1'b1;
        tick_check(NONE, "post_jump_reset", 0, 400, 300, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
